rtc_bus_write_responder: RTL and testbench

- Responder side of the user-control write request interface.
- Accepts level-held write requests: 8-bit RTC register address, 8-bit data and a request strobe.
- Turns each request into a multiplexed address/data write cycle on the external RTC bus (CS_n, WR_n, RD_n, A/D select, 8-bit AD bus).
- Answers each completed write with a single-cycle done pulse, so the requester steps to its next register.

---
 rtl/rtc_bus_write_responder.sv | 129 ++++++++++++
 tb/tb_rtc_bus_write_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_write_responder.sv
// Write-only responder for the external RTC bus: turns each level-held request into
// a multiplexed address/data write cycle and acknowledges it with a one-cycle fin pulse.
module rtc_bus_write_responder #(
  parameter int T_SU  = 2,
  parameter int T_PW  = 4,
  parameter int T_H   = 2,
  parameter int T_GAP = 3
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       escritura,
  input  logic [7:0] ADD2,
  input  logic [7:0] Dato_in,
  output logic       fin,
  output logic       busy,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       AD_sel,
  output logic [7:0] AD_out,
  output logic       AD_oe
);

  // Handshake: escritura is a level "valid"; the block is "ready" only in IDLE.
  // A request is taken at the first edge where escritura=1 in IDLE, inputs are
  // latched there and ignored until fin has pulsed and the GAP recovery has elapsed.

  typedef enum logic [3:0] {
    IDLE, A_SU, A_WR, A_H, D_SU, D_WR, D_H, DONE, GAP
  } state_t;

  localparam logic [7:0] SU_LD  = 8'(T_SU - 1);
  localparam logic [7:0] PW_LD  = 8'(T_PW - 1);
  localparam logic [7:0] H_LD   = 8'(T_H - 1);
  localparam logic [7:0] GAP_LD = 8'(T_GAP - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [7:0] addr_q, data_q, addr_nx, data_nx;
  logic       accept;
  logic       addr_phase, data_phase;
  logic       fin_nx, busy_nx, cs_n_nx, wr_n_nx, oe_nx, sel_nx;
  logic [7:0] out_nx;

  // Counter is loaded with (duration-1) on entry and the phase ends when it hits 0.
  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = 8'd0;
        if (escritura) begin
          accept   = 1'b1;
          state_nx = A_SU;
          cnt_nx   = SU_LD;
        end
      end
      A_SU: if (cnt == 8'd0) begin state_nx = A_WR; cnt_nx = PW_LD; end
      A_WR: if (cnt == 8'd0) begin state_nx = A_H;  cnt_nx = H_LD;  end
      A_H:  if (cnt == 8'd0) begin state_nx = D_SU; cnt_nx = SU_LD; end
      D_SU: if (cnt == 8'd0) begin state_nx = D_WR; cnt_nx = PW_LD; end
      D_WR: if (cnt == 8'd0) begin state_nx = D_H;  cnt_nx = H_LD;  end
      D_H:  if (cnt == 8'd0) begin state_nx = DONE; cnt_nx = 8'd0;  end
      DONE: begin
        state_nx = GAP;
        cnt_nx   = GAP_LD;
      end
      GAP:  if (cnt == 8'd0) state_nx = IDLE;
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    addr_nx    = accept ? ADD2 : addr_q;
    data_nx    = accept ? Dato_in : data_q;
    addr_phase = (state_nx == A_SU) || (state_nx == A_WR) || (state_nx == A_H);
    data_phase = (state_nx == D_SU) || (state_nx == D_WR) || (state_nx == D_H);
    fin_nx     = (state_nx == DONE);
    busy_nx    = (state_nx != IDLE);
    cs_n_nx    = !(addr_phase || data_phase);
    wr_n_nx    = !((state_nx == A_WR) || (state_nx == D_WR));
    oe_nx      = addr_phase || data_phase;
    sel_nx     = AD_sel;
    out_nx     = AD_out;
    if (addr_phase) begin
      sel_nx = 1'b0;
      out_nx = addr_nx;
    end else if (data_phase) begin
      sel_nx = 1'b1;
      out_nx = data_nx;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      addr_q <= 8'd0;
      data_q <= 8'd0;
      fin    <= 1'b0;
      busy   <= 1'b0;
      CS_n   <= 1'b1;
      WR_n   <= 1'b1;
      RD_n   <= 1'b1;
      AD_sel <= 1'b0;
      AD_out <= 8'd0;
      AD_oe  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
      data_q <= data_nx;
      fin    <= fin_nx;
      busy   <= busy_nx;
      CS_n   <= cs_n_nx;
      WR_n   <= wr_n_nx;
      RD_n   <= 1'b1;
      AD_sel <= sel_nx;
      AD_out <= out_nx;
      AD_oe  <= oe_nx;
    end
  end

endmodule

// File: tb/tb_rtc_bus_write_responder.sv
// Bench for rtc_bus_write_responder: default-timing instance plus a minimum-timing
// instance, both checked cycle by cycle against a transaction-offset reference model.
module tb_rtc_bus_write_responder;

  localparam int SU1 = 2, PW1 = 4, H1 = 2, G1 = 3;
  localparam int SU2 = 1, PW2 = 1, H2 = 1, G2 = 2;
  localparam int P1 = SU1 + PW1 + H1;
  localparam int P2 = SU2 + PW2 + H2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic       escritura = 1'b0;
  logic [7:0] ADD2 = 8'd0, Dato_in = 8'd0;
  logic       fin, busy, CS_n, WR_n, RD_n, AD_sel, AD_oe;
  logic [7:0] AD_out;

  logic       esc_f = 1'b0;
  logic [7:0] add_f = 8'd0, dat_f = 8'd0;
  logic       fin_f, busy_f, cs_n_f, wr_n_f, rd_n_f, sel_f, oe_f;
  logic [7:0] out_f;

  rtc_bus_write_responder #(.T_SU(SU1), .T_PW(PW1), .T_H(H1), .T_GAP(G1)) dut (
    .CLK(CLK), .reset(reset), .escritura(escritura), .ADD2(ADD2), .Dato_in(Dato_in),
    .fin(fin), .busy(busy), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
    .AD_sel(AD_sel), .AD_out(AD_out), .AD_oe(AD_oe)
  );

  rtc_bus_write_responder #(.T_SU(SU2), .T_PW(PW2), .T_H(H2), .T_GAP(G2)) dut_fast (
    .CLK(CLK), .reset(reset), .escritura(esc_f), .ADD2(add_f), .Dato_in(dat_f),
    .fin(fin_f), .busy(busy_f), .CS_n(cs_n_f), .WR_n(wr_n_f), .RD_n(rd_n_f),
    .AD_sel(sel_f), .AD_out(out_f), .AD_oe(oe_f)
  );

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected bus at transaction offset k (k<0: idle), derived from the phase timings.
  task automatic check_bus(input string p, input int k, input int su, input int pw,
                           input int h, input logic [7:0] ea, input logic [7:0] ed,
                           input logic o_fin, input logic o_busy, input logic o_cs,
                           input logic o_wr, input logic o_rd, input logic o_sel,
                           input logic [7:0] o_out, input logic o_oe);
    int P, j;
    P = su + pw + h;
    check({p, "_rd_n"}, o_rd, 1);
    if (k < 0) begin
      check({p, "_idle_fin"}, o_fin, 0);
      check({p, "_idle_busy"}, o_busy, 0);
      check({p, "_idle_cs_n"}, o_cs, 1);
      check({p, "_idle_wr_n"}, o_wr, 1);
      check({p, "_idle_oe"}, o_oe, 0);
    end else if (k < 2 * P) begin
      j = (k < P) ? k : k - P;
      check({p, "_fin"}, o_fin, 0);
      check({p, "_busy"}, o_busy, 1);
      check({p, "_cs_n"}, o_cs, 0);
      check({p, "_wr_n"}, o_wr, (j >= su && j < su + pw) ? 0 : 1);
      check({p, "_oe"}, o_oe, 1);
      check({p, "_sel"}, o_sel, (k >= P) ? 1 : 0);
      check({p, "_ad_out"}, o_out, (k >= P) ? ed : ea);
    end else if (k == 2 * P) begin
      check({p, "_done_fin"}, o_fin, 1);
      check({p, "_done_busy"}, o_busy, 1);
      check({p, "_done_cs_n"}, o_cs, 1);
      check({p, "_done_wr_n"}, o_wr, 1);
      check({p, "_done_oe"}, o_oe, 0);
      check({p, "_done_ad_out"}, o_out, ed);
    end else begin
      check({p, "_gap_fin"}, o_fin, 0);
      check({p, "_gap_busy"}, o_busy, 1);
      check({p, "_gap_cs_n"}, o_cs, 1);
      check({p, "_gap_wr_n"}, o_wr, 1);
      check({p, "_gap_oe"}, o_oe, 0);
    end
  endtask

  // ---------------- reference model ----------------
  // k counts cycles since the accept edge; the transaction is over 2P+1+GAP edges later.
  int         m1_k = -1, m2_k = -1;
  logic [7:0] m1_a = 8'd0, m1_d = 8'd0, m2_a = 8'd0, m2_d = 8'd0;
  logic [15:0] exp_q[$];

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      m1_k <= -1;
      exp_q.delete();
    end else if (m1_k < 0) begin
      if (escritura) begin
        m1_k <= 0;
        m1_a <= ADD2;
        m1_d <= Dato_in;
        exp_q.push_back({ADD2, Dato_in});
      end
    end else if (m1_k == 2 * P1 + G1) m1_k <= -1;
    else m1_k <= m1_k + 1;
  end

  always @(posedge CLK or negedge reset) begin
    if (!reset) m2_k <= -1;
    else if (m2_k < 0) begin
      if (esc_f) begin
        m2_k <= 0;
        m2_a <= add_f;
        m2_d <= dat_f;
      end
    end else if (m2_k == 2 * P2 + G2) m2_k <= -1;
    else m2_k <= m2_k + 1;
  end

  // ---------------- monitors / scoreboard ----------------
  int         rise1_cyc = 0, rise2_cyc = 0;
  logic       b1_prev = 1'b0, b2_prev = 1'b0, r2_valid = 1'b0;
  logic [7:0] cap_a = 8'd0, cap_d = 8'd0;
  logic [15:0] e;

  initial forever begin
    @(negedge CLK);
    check_bus("d1", m1_k, SU1, PW1, H1, m1_a, m1_d,
              fin, busy, CS_n, WR_n, RD_n, AD_sel, AD_out, AD_oe);
    if (busy && !b1_prev) rise1_cyc = cyc;
    b1_prev = busy;
    if (!WR_n && !AD_sel) cap_a = AD_out;
    if (!WR_n && AD_sel)  cap_d = AD_out;
    if (fin) begin
      if (exp_q.size() == 0) check("sb_unexpected_fin", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sb_addr", cap_a, e[15:8]);
        check("sb_data", cap_d, e[7:0]);
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    check_bus("d2", m2_k, SU2, PW2, H2, m2_a, m2_d,
              fin_f, busy_f, cs_n_f, wr_n_f, rd_n_f, sel_f, out_f, oe_f);
    if (!reset) r2_valid = 1'b0;
    else if (busy_f && !b2_prev) begin
      if (r2_valid) check("fast_accept_spacing", cyc - rise2_cyc, 2 * P2 + 2 + G2);
      r2_valid  = 1'b1;
      rise2_cyc = cyc;
    end
    if (fin_f) check("fast_fin_latency", cyc - rise2_cyc, 2 * P2);
    b2_prev = busy_f;
  end

  // Fast instance: request held high, operands changing every cycle.
  initial begin
    @(posedge reset);
    forever begin
      @(posedge CLK);
      #1;
      esc_f = 1'b1;
      add_f = 8'($urandom);
      dat_f = 8'($urandom);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge CLK);
    #1;
    escritura = 1'b1;
    ADD2      = a;
    Dato_in   = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_fin();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (fin) seen = 1'b1;
    end
    if (!seen) check("fin_timeout", 0, 1);
    else check("fin_latency", cyc - rise1_cyc, 2 * P1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge CLK);
  endtask

  // ---------------- main sequence ----------------
  int r_first;

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check("rst_fin", fin, 0);
    check("rst_busy", busy, 0);
    check("rst_cs_n", CS_n, 1);
    check("rst_wr_n", WR_n, 1);
    check("rst_rd_n", RD_n, 1);
    check("rst_sel", AD_sel, 0);
    check("rst_ad_out", AD_out, 0);
    check("rst_oe", AD_oe, 0);
    @(posedge CLK);
    #2 reset = 1'b1;

    // single write
    start_write(8'h21, 8'h45);
    escritura = 1'b0;
    wait_fin();
    settle(6);

    // back-to-back with level-held request
    @(posedge CLK);
    #1;
    escritura = 1'b1; ADD2 = 8'h21; Dato_in = 8'h45;
    wait_fin();
    r_first = rise1_cyc;
    @(posedge CLK);
    #1;
    ADD2 = 8'h22; Dato_in = 8'h12;
    wait_fin();
    check("b2b_accept_spacing", rise1_cyc - r_first, 2 * P1 + 2 + G1);
    escritura = 1'b0;
    settle(6);

    // address input changes mid-transaction
    start_write(8'h21, 8'h45);
    escritura = 1'b0;
    repeat (4) @(posedge CLK);
    #1 ADD2 = 8'h50;
    wait_fin();
    settle(6);

    // request dropped at A+3
    start_write(8'h33, 8'h77);
    repeat (2) @(posedge CLK);
    #1 escritura = 1'b0;
    wait_fin();
    repeat (G1 + 4) @(negedge CLK);
    check("no_reaccept_busy", busy, 0);

    // asynchronous reset inside D_SU
    start_write(8'h21, 8'h45);
    escritura = 1'b0;
    repeat (8) @(posedge CLK);
    #2 reset = 1'b0;
    #1;
    check("arst_cs_n", CS_n, 1);
    check("arst_wr_n", WR_n, 1);
    check("arst_oe", AD_oe, 0);
    check("arst_busy", busy, 0);
    check("arst_fin", fin, 0);
    check("arst_ad_out", AD_out, 0);
    repeat (2) @(posedge CLK);
    #2 reset = 1'b1;
    start_write(8'h21, 8'h45);
    escritura = 1'b0;
    wait_fin();
    settle(6);

    // random requests
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK);
      #1;
      escritura = ($urandom_range(0, 3) != 0);
      ADD2      = 8'($urandom);
      Dato_in   = 8'($urandom);
    end
    escritura = 1'b0;
    settle(40);
    check("sb_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
